alu_result_collector: RTL and testbench

ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/alu_result_collector.sv | 143 ++++++++++++++
 tb/tb_alu_result_collector.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU result collector:
//   - 2-bit result class encoding carried alongside each queued result
//   - 4-bit ALU function codes used by the surrounding datapath
//   - helper functions to decode the one-hot operation-class flags
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    // Result class encoding (stored in the FIFO next to the data word)
    localparam logic [1:0] CLS_ARITH = 2'd0;
    localparam logic [1:0] CLS_LOGIC = 2'd1;
    localparam logic [1:0] CLS_CMP   = 2'd2;
    localparam logic [1:0] CLS_SHIFT = 2'd3;

    // ALU function codes
    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_OR  = 4'h3;
    localparam logic [3:0] FN_XOR = 4'h4;
    localparam logic [3:0] FN_NOT = 4'h5;
    localparam logic [3:0] FN_CMP = 4'h6;
    localparam logic [3:0] FN_SLL = 4'h7;
    localparam logic [3:0] FN_SRL = 4'h8;
    localparam logic [3:0] FN_SRA = 4'h9;

    // Flags are packed as {shift, cmp, logic, arith}; bit index equals class.
    function automatic logic [1:0] encode_class(input logic [3:0] flags);
        logic [1:0] cls;
        cls = CLS_ARITH;
        if (flags[1]) cls = CLS_LOGIC;
        if (flags[2]) cls = CLS_CMP;
        if (flags[3]) cls = CLS_SHIFT;
        return cls;
    endfunction

    // True when two or more flags are set (clears the lowest set bit).
    function automatic logic multi_flag(input logic [3:0] flags);
        return (flags & (flags - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational (first-word fall-through) head.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i/wdata_i write request and data
//   pop_i          read request (ignored when empty)
//   rdata_o        head entry, forced to zero while empty
//   full_o/empty_o occupancy status
// A push while full is accepted only together with a pop in the same cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
// Captures ALU results tagged with their operation class into a FIFO and
// presents them to a downstream consumer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ALU_OUT                  registered ALU result
//   arith/logic/cmp/shift_flag  operation-class flags aligned with ALU_OUT
//   collect_en               capture enable
//   err_clr                  clears sticky errors (and statistics)
//   out_ready/out_valid      downstream handshake
//   out_data/out_class       head entry
//   fifo_full, fifo_empty    occupancy status
//   overflow_err, flag_err   sticky error flags
//   cnt_arith..cnt_shift     per-class accepted-push counters, present only
//                            when ALU_COLLECT_STATS_EN is defined
// Handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready, and
// out_data/out_class hold while out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic              arith_flag,
    input  logic              logic_flag,
    input  logic              cmp_flag,
    input  logic              shift_flag,
    input  logic              collect_en,
    input  logic              err_clr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_class,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow_err,
    output logic              flag_err
`ifdef ALU_COLLECT_STATS_EN
    ,
    output logic [7:0]        cnt_arith,
    output logic [7:0]        cnt_logic,
    output logic [7:0]        cnt_cmp,
    output logic [7:0]        cnt_shift
`endif
);
    logic [3:0]        flags;
    logic              one_hot, multi;
    logic              capture, pop, push, ovf_evt, flag_evt;
    logic [1:0]        cls;
    logic [DATA_W+1:0] head;
    logic              overflow_err_q, overflow_err_d;
    logic              flag_err_q, flag_err_d;

    assign flags   = {shift_flag, cmp_flag, logic_flag, arith_flag};
    assign multi   = multi_flag(flags);
    assign one_hot = (flags != 4'd0) && !multi;
    assign cls     = encode_class(flags);

    assign capture  = collect_en & one_hot;
    assign pop      = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = capture & (~fifo_full | pop);
    assign ovf_evt  = capture & fifo_full & ~pop;
    assign flag_evt = collect_en & multi;

    sync_fifo #(
        .WIDTH(DATA_W + 2),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .wdata_i({cls, ALU_OUT}),
        .pop_i  (pop),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_class = head[DATA_W+1:DATA_W];

    // A same-cycle error event wins over err_clr.
    always_comb begin
        overflow_err_d = overflow_err_q;
        flag_err_d     = flag_err_q;
        if (err_clr) begin
            overflow_err_d = 1'b0;
            flag_err_d     = 1'b0;
        end
        if (ovf_evt)  overflow_err_d = 1'b1;
        if (flag_evt) flag_err_d     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err_q <= 1'b0;
            flag_err_q     <= 1'b0;
        end else begin
            overflow_err_q <= overflow_err_d;
            flag_err_q     <= flag_err_d;
        end
    end

    assign overflow_err = overflow_err_q;
    assign flag_err     = flag_err_q;

`ifdef ALU_COLLECT_STATS_EN
    // Counters indexed by class; saturate at 255, err_clr wins over a push.
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
        if (err_clr) begin
            for (int i = 0; i < 4; i++) cnt_d[i] = 8'd0;
        end else if (push && cnt_q[cls] != 8'hFF) begin
            cnt_d[cls] = cnt_q[cls] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign cnt_arith = cnt_q[CLS_ARITH];
    assign cnt_logic = cnt_q[CLS_LOGIC];
    assign cnt_cmp   = cnt_q[CLS_CMP];
    assign cnt_shift = cnt_q[CLS_SHIFT];
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_alu_result_collector
// Self-checking bench for alu_result_collector. Inputs change 1 time unit
// after the rising edge; outputs are sampled there or on the falling edge.
// Accepted captures push {class, data} onto exp_q; the pop monitor compares
// every handshake against the queue head.
// -----------------------------------------------------------------------------
module tb_alu_result_collector;
    localparam int DW = 16;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ALU_OUT = '0;
    logic          arith_flag = 1'b0, logic_flag = 1'b0;
    logic          cmp_flag = 1'b0, shift_flag = 1'b0;
    logic          collect_en = 1'b0, err_clr = 1'b0, out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_class;
    logic          fifo_full, fifo_empty, overflow_err, flag_err;
`ifdef ALU_COLLECT_STATS_EN
    logic [7:0]    cnt_arith, cnt_logic, cnt_cmp, cnt_shift;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [DW+1:0] exp_q[$];

    alu_result_collector #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .ALU_OUT(ALU_OUT),
        .arith_flag(arith_flag), .logic_flag(logic_flag),
        .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .collect_en(collect_en), .err_clr(err_clr), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_class(out_class),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow_err(overflow_err), .flag_err(flag_err)
`ifdef ALU_COLLECT_STATS_EN
        , .cnt_arith(cnt_arith), .cnt_logic(cnt_logic),
        .cnt_cmp(cnt_cmp), .cnt_shift(cnt_shift)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- pop monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [DW+1:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got data=%0d class=%0d, required no entry", out_data, out_class);
            end else begin
                e = exp_q.pop_front();
                if ({out_class, out_data} !== e) begin
                    miscompares++;
                    $display("FAIL pop_order: got data=%0d class=%0d, required data=%0d class=%0d",
                             out_data, out_class, e[DW-1:0], e[DW+1:DW]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [DW-1:0] d, input logic [3:0] f);
        ALU_OUT = d;
        {shift_flag, cmp_flag, logic_flag, arith_flag} = f;
        collect_en = 1'b1;
        step();
        collect_en = 1'b0;
        {shift_flag, cmp_flag, logic_flag, arith_flag} = 4'd0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    function automatic logic [3:0] cls_flag(input int c);
        logic [3:0] f;
        f = 4'd1 << c;
        return f;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        step(); step();
        vectors++;
        if ({out_valid, fifo_empty, fifo_full, overflow_err, flag_err, out_data, out_class} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%0b empty=%0b full=%0b ovf=%0b ferr=%0b data=%0d class=%0d",
                     out_valid, fifo_empty, fifo_full, overflow_err, flag_err, out_data, out_class);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        exp_q.push_back({2'd0, DW'(35)});
        capture(DW'(35), 4'b0001);
        vectors++;
        if ({out_valid, out_data, out_class} !== {1'b1, DW'(35), 2'd0}) begin
            miscompares++;
            $display("FAIL single_latency: got valid=%0b data=%0d class=%0d, required 1/35/0",
                     out_valid, out_data, out_class);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drained: got valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4];
        int            cl [4];
        vals = '{DW'(5), DW'(300), DW'(2), DW'(40)};
        cl   = '{1, 0, 2, 3};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'(cl[i]), vals[i]});
            capture(vals[i], cls_flag(cl[i]));
        end
        vectors++;
        if ({fifo_full, fifo_empty} !== 2'b10) begin
            miscompares++;
            $display("FAIL fill_full: got full=%0b empty=%0b, required 1/0", fifo_full, fifo_empty);
        end
        step(); step();
        vectors++;
        if ({out_valid, out_data, out_class} !== {1'b1, DW'(5), 2'd1}) begin
            miscompares++;
            $display("FAIL hold_stable: got valid=%0b data=%0d class=%0d, required 1/5/1",
                     out_valid, out_data, out_class);
        end
        out_ready = 1'b1;
        repeat (DP + 1) step();
        vectors++;
        if (fifo_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_empty: got empty=%0b, required 1", fifo_empty);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] v;
        // Part 1: fifth capture while full and stalled is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < DP; i++) begin
            v = DW'($urandom_range(0, 65535));
            exp_q.push_back({2'(i), v});
            capture(v, cls_flag(i));
        end
        capture(DW'(16'hBEEF), 4'b0001);
        vectors++;
        if ({overflow_err, fifo_full} !== 2'b11 || {out_class, out_data} !== exp_q[0]) begin
            miscompares++;
            $display("FAIL overflow_drop: got ovf=%0b full=%0b head=%0h, required 1/1 head=%0h",
                     overflow_err, fifo_full, {out_class, out_data}, exp_q[0]);
        end
        out_ready = 1'b1;
        repeat (DP + 2) step();
        vectors++;
        if ({fifo_empty, overflow_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL overflow_drained: got empty=%0b ovf=%0b, required 1/1", fifo_empty, overflow_err);
        end
        clear_errors();
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got ovf=%0b, required 0", overflow_err);
        end
        // Part 2: capture while full with a simultaneous pop is accepted.
        out_ready = 1'b0;
        for (int i = 0; i < DP; i++) begin
            v = DW'($urandom_range(0, 65535));
            exp_q.push_back({2'(3 - i), v});
            capture(v, cls_flag(3 - i));
        end
        out_ready = 1'b1;
        exp_q.push_back({2'd2, DW'(16'h1234)});
        capture(DW'(16'h1234), 4'b0100);
        vectors++;
        if ({fifo_full, overflow_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_with_pop: got full=%0b ovf=%0b, required 1/0", fifo_full, overflow_err);
        end
        repeat (DP + 2) step();
        vectors++;
        if ({fifo_empty, overflow_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_with_pop_drain: got empty=%0b ovf=%0b, required 1/0", fifo_empty, overflow_err);
        end
    endtask

    task automatic test_flag_err();
        out_ready = 1'b1;
        capture(DW'(77), 4'b0101);
        vectors++;
        if ({flag_err, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL multi_flag: got ferr=%0b valid=%0b, required 1/0", flag_err, out_valid);
        end
        capture(DW'(88), 4'b0000);
        vectors++;
        if ({flag_err, out_valid, overflow_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL nop_no_push: got ferr=%0b valid=%0b ovf=%0b, required 1/0/0",
                     flag_err, out_valid, overflow_err);
        end
        clear_errors();
        vectors++;
        if (flag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL flag_clear: got ferr=%0b, required 0", flag_err);
        end
        // Error event in the same cycle as err_clr keeps the flag set.
        err_clr = 1'b1;
        capture(DW'(9), 4'b1010);
        err_clr = 1'b0;
        vectors++;
        if (flag_err !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_priority: got ferr=%0b, required 1", flag_err);
        end
        clear_errors();
    endtask

    task automatic test_back_to_back();
        int         occ = 0;
        logic       ovf_m = 1'b0, ferr_m = 1'b0;
        logic [3:0] f;
        logic       en, rdy, pop_m, oh, mu;
        logic [DW-1:0] d;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0:       f = 4'd0;
                1:       f = 4'(cls_flag($urandom_range(0, 3)) | cls_flag($urandom_range(0, 3)));
                default: f = cls_flag($urandom_range(0, 3));
            endcase
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            d   = DW'($urandom_range(0, 65535));
            oh  = (f != 4'd0) && ((f & (f - 4'd1)) == 4'd0);
            mu  = (f != 4'd0) && !oh;
            pop_m = rdy && (occ > 0);
            if (en && oh && (occ < DP || pop_m)) begin
                exp_q.push_back({2'($clog2(int'(f))), d});
                occ++;
            end else if (en && oh) begin
                ovf_m = 1'b1;
            end
            if (en && mu) ferr_m = 1'b1;
            if (pop_m) occ--;
            out_ready = rdy;
            ALU_OUT = d;
            {shift_flag, cmp_flag, logic_flag, arith_flag} = f;
            collect_en = en;
            step();
            vectors++;
            if ({overflow_err, flag_err, fifo_full, fifo_empty} !==
                {ovf_m, ferr_m, (occ == DP), (occ == 0)}) begin
                miscompares++;
                $display("FAIL random_status[%0d]: got ovf=%0b ferr=%0b full=%0b empty=%0b, required %0b/%0b/%0b/%0b",
                         n, overflow_err, flag_err, fifo_full, fifo_empty,
                         ovf_m, ferr_m, (occ == DP), (occ == 0));
            end
        end
        collect_en = 1'b0;
        {shift_flag, cmp_flag, logic_flag, arith_flag} = 4'd0;
        out_ready = 1'b1;
        repeat (DP + 2) step();
        clear_errors();
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) capture(DW'(100 + i), cls_flag(i));
        capture(DW'(1), 4'b0011);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        vectors++;
        if ({fifo_empty, out_valid, overflow_err, flag_err, out_data} !== {4'b1000, {DW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_flush: got empty=%0b valid=%0b ovf=%0b ferr=%0b data=%0d, required 1/0/0/0/0",
                     fifo_empty, out_valid, overflow_err, flag_err, out_data);
        end
        out_ready = 1'b1;
        step();
    endtask

`ifdef ALU_COLLECT_STATS_EN
    task automatic test_stats();
        out_ready = 1'b1;
        clear_errors();
        for (int i = 0; i < 260; i++) begin
            exp_q.push_back({2'd0, DW'(i)});
            capture(DW'(i), 4'b0001);
        end
        vectors++;
        if ({cnt_arith, cnt_logic} !== {8'd255, 8'd0}) begin
            miscompares++;
            $display("FAIL stats_saturate: got arith=%0d logic=%0d, required 255/0", cnt_arith, cnt_logic);
        end
        step(); step();
        clear_errors();
        vectors++;
        if (cnt_arith !== 8'd0) begin
            miscompares++;
            $display("FAIL stats_clear: got arith=%0d, required 0", cnt_arith);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_flag_err();
        test_back_to_back();
`ifdef ALU_COLLECT_STATS_EN
        test_stats();
`endif
        test_reset_flush();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_entries: got %0d undelivered, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
